// File: rtl/ibex_rvfi_trace_buffer.sv
// Trace capture buffer for the RVFI retirement stream.
// The buffer runs in one of two modes:
//   STREAM - a plain FIFO. Records that arrive while it is full are dropped
//            and counted.
//   FLIGHT - a circular flight recorder. It overwrites the oldest record until
//            a trigger fires, then keeps a programmed number of post-trigger
//            records and freezes in DONE.
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   rvfi_*_i                retirement record (valid strobe plus fields)
//   arm_i                   clear the buffer and latch mode_i, trig_sel_i,
//                           trig_pc_i and post_cnt_i
//   rd_valid_o, rd_ready_i  readout handshake, head record first
//   rd_*_o                  head record fields, 0 when rd_valid_o is low
//   count_o                 occupancy
//   state_o                 0 IDLE, 1 ARMED, 2 POST, 3 DONE
//   dropped_o               saturating count of records lost in STREAM mode
module ibex_rvfi_trace_buffer #(
  parameter int unsigned Depth      = 16,
  parameter int unsigned TsWidth    = 16,
  parameter bit          CaptureMem = 1'b1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     rvfi_valid_i,
  input  logic [31:0]              rvfi_insn_i,
  input  logic [31:0]              rvfi_pc_rdata_i,
  input  logic                     rvfi_trap_i,
  input  logic [4:0]               rvfi_rd_addr_i,
  input  logic [31:0]              rvfi_rd_wdata_i,
  input  logic [31:0]              rvfi_mem_addr_i,
  input  logic [3:0]               rvfi_mem_rmask_i,
  input  logic [3:0]               rvfi_mem_wmask_i,
  input  logic                     arm_i,
  input  logic                     mode_i,
  input  logic [1:0]               trig_sel_i,
  input  logic [31:0]              trig_pc_i,
  input  logic [$clog2(Depth)-1:0] post_cnt_i,
  output logic                     rd_valid_o,
  input  logic                     rd_ready_i,
  output logic [31:0]              rd_pc_o,
  output logic [31:0]              rd_insn_o,
  output logic [31:0]              rd_rd_wdata_o,
  output logic [31:0]              rd_mem_addr_o,
  output logic [4:0]               rd_rd_addr_o,
  output logic                     rd_trap_o,
  output logic [7:0]               rd_mem_mask_o,
  output logic [TsWidth-1:0]       rd_ts_o,
  output logic [$clog2(Depth):0]   count_o,
  output logic [1:0]               state_o,
  output logic [15:0]              dropped_o
);

  localparam int unsigned AW = $clog2(Depth);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StArmed = 2'd1,
    StPost  = 2'd2,
    StDone  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic                mode_q, mode_d;
  logic [1:0]          sel_q, sel_d;
  logic [31:0]         trig_pc_q, trig_pc_d;
  logic [AW-1:0]       post_q, post_d;
  logic [AW-1:0]       rem_q, rem_d;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic [TsWidth-1:0]  ts_q, ts_d;
  logic [15:0]         dropped_q, dropped_d;

  logic capture, full, rd_valid, push, pop, drop, trig_hit;

  assign capture  = rvfi_valid_i && (state_q == StArmed || state_q == StPost);
  assign full     = (count_q == CW'(Depth));
  // A flight recording only becomes readable once it is frozen.
  assign rd_valid = (count_q != '0) && (!mode_q || state_q == StDone);

  // Next-state, pointer and counter logic; arm_i overrides everything else.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    sel_d     = sel_q;
    trig_pc_d = trig_pc_q;
    post_d    = post_q;
    rem_d     = rem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    ts_d      = ts_q + TsWidth'(1);
    dropped_d = dropped_q;
    push      = 1'b0;
    pop       = 1'b0;
    drop      = 1'b0;
    trig_hit  = (sel_q == 2'b00) ||
                (sel_q[0] && rvfi_pc_rdata_i == trig_pc_q) ||
                (sel_q[1] && rvfi_trap_i);

    if (arm_i) begin
      state_d   = StArmed;
      mode_d    = mode_i;
      sel_d     = trig_sel_i;
      trig_pc_d = trig_pc_i;
      post_d    = post_cnt_i;
      rem_d     = '0;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      ts_d      = '0;
      dropped_d = '0;
    end else begin
      pop = rd_valid && rd_ready_i;
      if (!mode_q) begin
        // A full FIFO still takes a record when the head leaves this cycle.
        push = capture && (!full || pop);
        drop = capture && !push;
      end else begin
        push = capture;
      end

      if (mode_q && capture) begin
        if (state_q == StArmed && trig_hit) begin
          if (post_q == '0) begin
            state_d = StDone;
          end else begin
            state_d = StPost;
            rem_d   = post_q;
          end
        end else if (state_q == StPost) begin
          rem_d = rem_q - AW'(1);
          if (rem_q == AW'(1)) begin
            state_d = StDone;
          end
        end
      end

      if (push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      // A push into a full buffer (pop or overwrite) retires the oldest entry.
      if (pop || (push && full)) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (push && !pop && !full) begin
        count_d = count_q + CW'(1);
      end else if (pop && !push) begin
        count_d = count_q - CW'(1);
      end

      if (drop && dropped_q != 16'hFFFF) begin
        dropped_d = dropped_q + 16'd1;
      end
    end
  end

  // Control state registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      mode_q    <= 1'b0;
      sel_q     <= 2'b00;
      trig_pc_q <= '0;
      post_q    <= '0;
      rem_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ts_q      <= '0;
      dropped_q <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      sel_q     <= sel_d;
      trig_pc_q <= trig_pc_d;
      post_q    <= post_d;
      rem_q     <= rem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ts_q      <= ts_d;
      dropped_q <= dropped_d;
    end
  end

  // Record storage. No reset here: head fields are gated by rd_valid instead.
  logic [31:0]        pc_mem    [Depth];
  logic [31:0]        insn_mem  [Depth];
  logic [31:0]        wdata_mem [Depth];
  logic [4:0]         rd_mem    [Depth];
  logic               trap_mem  [Depth];
  logic [TsWidth-1:0] ts_mem    [Depth];

  always_ff @(posedge clk_i) begin
    if (push) begin
      pc_mem[wr_ptr_q]    <= rvfi_pc_rdata_i;
      insn_mem[wr_ptr_q]  <= rvfi_insn_i;
      wdata_mem[wr_ptr_q] <= rvfi_rd_wdata_i;
      rd_mem[wr_ptr_q]    <= rvfi_rd_addr_i;
      trap_mem[wr_ptr_q]  <= rvfi_trap_i;
      ts_mem[wr_ptr_q]    <= ts_q;
    end
  end

  if (CaptureMem) begin : g_mem
    logic [31:0] maddr_mem [Depth];
    logic [7:0]  mask_mem  [Depth];

    always_ff @(posedge clk_i) begin
      if (push) begin
        maddr_mem[wr_ptr_q] <= rvfi_mem_addr_i;
        mask_mem[wr_ptr_q]  <= {rvfi_mem_wmask_i, rvfi_mem_rmask_i};
      end
    end

    assign rd_mem_addr_o = rd_valid ? maddr_mem[rd_ptr_q] : '0;
    assign rd_mem_mask_o = rd_valid ? mask_mem[rd_ptr_q]  : '0;
  end else begin : g_no_mem
    logic unused_mem;
    assign unused_mem    = ^{rvfi_mem_addr_i, rvfi_mem_rmask_i, rvfi_mem_wmask_i};
    assign rd_mem_addr_o = '0;
    assign rd_mem_mask_o = '0;
  end

  assign rd_valid_o    = rd_valid;
  assign rd_pc_o       = rd_valid ? pc_mem[rd_ptr_q]    : '0;
  assign rd_insn_o     = rd_valid ? insn_mem[rd_ptr_q]  : '0;
  assign rd_rd_wdata_o = rd_valid ? wdata_mem[rd_ptr_q] : '0;
  assign rd_rd_addr_o  = rd_valid ? rd_mem[rd_ptr_q]    : '0;
  assign rd_trap_o     = rd_valid ? trap_mem[rd_ptr_q]  : 1'b0;
  assign rd_ts_o       = rd_valid ? ts_mem[rd_ptr_q]    : '0;
  assign count_o       = count_q;
  assign state_o       = state_q;
  assign dropped_o     = dropped_q;

endmodule

// File: tb/tb_ibex_rvfi_trace_buffer.sv
module tb_ibex_rvfi_trace_buffer;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        rvfi_valid_i;
  logic [31:0] rvfi_insn_i;
  logic [31:0] rvfi_pc_rdata_i;
  logic        rvfi_trap_i;
  logic [4:0]  rvfi_rd_addr_i;
  logic [31:0] rvfi_rd_wdata_i;
  logic [31:0] rvfi_mem_addr_i;
  logic [3:0]  rvfi_mem_rmask_i;
  logic [3:0]  rvfi_mem_wmask_i;
  logic        arm_i;
  logic        mode_i;
  logic [1:0]  trig_sel_i;
  logic [31:0] trig_pc_i;
  logic [3:0]  post_cnt_i;
  logic        rd_valid_o;
  logic        rd_ready_i;
  logic [31:0] rd_pc_o, rd_insn_o, rd_rd_wdata_o, rd_mem_addr_o;
  logic [4:0]  rd_rd_addr_o;
  logic        rd_trap_o;
  logic [7:0]  rd_mem_mask_o;
  logic [15:0] rd_ts_o;
  logic [4:0]  count_o;
  logic [1:0]  state_o;
  logic [15:0] dropped_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ibex_rvfi_trace_buffer dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .rvfi_valid_i     (rvfi_valid_i),
    .rvfi_insn_i      (rvfi_insn_i),
    .rvfi_pc_rdata_i  (rvfi_pc_rdata_i),
    .rvfi_trap_i      (rvfi_trap_i),
    .rvfi_rd_addr_i   (rvfi_rd_addr_i),
    .rvfi_rd_wdata_i  (rvfi_rd_wdata_i),
    .rvfi_mem_addr_i  (rvfi_mem_addr_i),
    .rvfi_mem_rmask_i (rvfi_mem_rmask_i),
    .rvfi_mem_wmask_i (rvfi_mem_wmask_i),
    .arm_i            (arm_i),
    .mode_i           (mode_i),
    .trig_sel_i       (trig_sel_i),
    .trig_pc_i        (trig_pc_i),
    .post_cnt_i       (post_cnt_i),
    .rd_valid_o       (rd_valid_o),
    .rd_ready_i       (rd_ready_i),
    .rd_pc_o          (rd_pc_o),
    .rd_insn_o        (rd_insn_o),
    .rd_rd_wdata_o    (rd_rd_wdata_o),
    .rd_mem_addr_o    (rd_mem_addr_o),
    .rd_rd_addr_o     (rd_rd_addr_o),
    .rd_trap_o        (rd_trap_o),
    .rd_mem_mask_o    (rd_mem_mask_o),
    .rd_ts_o          (rd_ts_o),
    .count_o          (count_o),
    .state_o          (state_o),
    .dropped_o        (dropped_o)
  );

  typedef struct {
    logic        arm;
    logic        mode;
    logic [1:0]  sel;
    logic [3:0]  post;
    logic        valid;
    logic [31:0] pc;
    logic        ready;
    logic [4:0]  e_cnt;
    logic [1:0]  e_st;
    logic        e_rv;
    logic [31:0] e_pc;
    logic [15:0] e_drop;
  } vec_t;

  vec_t vecs[13];

  function automatic vec_t mk(logic arm, logic mode, logic [1:0] sel, logic [3:0] post,
                              logic valid, logic [31:0] pc, logic ready, logic [4:0] e_cnt,
                              logic [1:0] e_st, logic e_rv, logic [31:0] e_pc,
                              logic [15:0] e_drop);
    vec_t v;
    v.arm = arm; v.mode = mode; v.sel = sel; v.post = post; v.valid = valid;
    v.pc = pc; v.ready = ready; v.e_cnt = e_cnt; v.e_st = e_st; v.e_rv = e_rv;
    v.e_pc = e_pc; v.e_drop = e_drop;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rvfi_valid_i = 1'b0; rvfi_trap_i = 1'b0; rvfi_pc_rdata_i = '0;
    arm_i = 1'b0; rd_ready_i = 1'b0;
  endtask

  task automatic do_arm(input logic mode, input logic [1:0] sel, input logic [31:0] tpc,
                        input logic [3:0] post);
    arm_i = 1'b1; mode_i = mode; trig_sel_i = sel; trig_pc_i = tpc; post_cnt_i = post;
    step();
    arm_i = 1'b0;
  endtask

  task automatic retire(input logic [31:0] pc, input logic trap);
    rvfi_valid_i = 1'b1; rvfi_pc_rdata_i = pc; rvfi_trap_i = trap;
    rvfi_insn_i = pc ^ 32'h13; rvfi_rd_wdata_i = ~pc;
    rvfi_mem_addr_i = pc + 32'h1000;
    step();
    rvfi_valid_i = 1'b0; rvfi_trap_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1;
    idle_inputs();
    mode_i = 1'b0; trig_sel_i = 2'b00; trig_pc_i = '0; post_cnt_i = '0;
    rvfi_insn_i = '0; rvfi_rd_addr_i = 5'd3; rvfi_rd_wdata_i = '0;
    rvfi_mem_addr_i = '0; rvfi_mem_rmask_i = 4'h3; rvfi_mem_wmask_i = 4'hC;

    vecs[0]  = mk(1, 0, 2'b00, 4'd0, 0, 32'h0,   0, 5'd0, 2'd1, 0, 32'h0,   16'd0);
    vecs[1]  = mk(0, 0, 2'b00, 4'd0, 1, 32'h100, 0, 5'd1, 2'd1, 1, 32'h100, 16'd0);
    vecs[2]  = mk(0, 0, 2'b00, 4'd0, 1, 32'h104, 0, 5'd2, 2'd1, 1, 32'h100, 16'd0);
    vecs[3]  = mk(0, 0, 2'b00, 4'd0, 1, 32'h108, 1, 5'd2, 2'd1, 1, 32'h104, 16'd0);
    vecs[4]  = mk(0, 0, 2'b00, 4'd0, 0, 32'h0,   1, 5'd1, 2'd1, 1, 32'h108, 16'd0);
    vecs[5]  = mk(0, 0, 2'b00, 4'd0, 0, 32'h0,   1, 5'd0, 2'd1, 0, 32'h0,   16'd0);
    vecs[6]  = mk(0, 0, 2'b00, 4'd0, 0, 32'h0,   1, 5'd0, 2'd1, 0, 32'h0,   16'd0);
    vecs[7]  = mk(1, 1, 2'b00, 4'd1, 0, 32'h0,   0, 5'd0, 2'd1, 0, 32'h0,   16'd0);
    vecs[8]  = mk(0, 1, 2'b00, 4'd1, 1, 32'h200, 0, 5'd1, 2'd2, 0, 32'h0,   16'd0);
    vecs[9]  = mk(0, 1, 2'b00, 4'd1, 1, 32'h204, 0, 5'd2, 2'd3, 1, 32'h200, 16'd0);
    vecs[10] = mk(0, 1, 2'b00, 4'd1, 1, 32'h208, 0, 5'd2, 2'd3, 1, 32'h200, 16'd0);
    vecs[11] = mk(0, 1, 2'b00, 4'd1, 0, 32'h0,   1, 5'd1, 2'd3, 1, 32'h204, 16'd0);
    vecs[12] = mk(0, 1, 2'b00, 4'd1, 0, 32'h0,   1, 5'd0, 2'd3, 0, 32'h0,   16'd0);

    step();
    check("reset_state", 64'(state_o), 64'd0);
    check("reset_count", 64'(count_o), 64'd0);
    check("reset_rd_valid", 64'(rd_valid_o), 64'd0);
    check("reset_dropped", 64'(dropped_o), 64'd0);
    rst_i = 1'b0;
    step();

    // Table-driven cycles: STREAM push/pop, then a short FLIGHT capture.
    for (int i = 0; i < 13; i++) begin
      arm_i = vecs[i].arm; mode_i = vecs[i].mode; trig_sel_i = vecs[i].sel;
      post_cnt_i = vecs[i].post; rvfi_valid_i = vecs[i].valid;
      rvfi_pc_rdata_i = vecs[i].pc; rd_ready_i = vecs[i].ready; rvfi_trap_i = 1'b0;
      step();
      check($sformatf("vec%0d_count", i), 64'(count_o), 64'(vecs[i].e_cnt));
      check($sformatf("vec%0d_state", i), 64'(state_o), 64'(vecs[i].e_st));
      check($sformatf("vec%0d_rd_valid", i), 64'(rd_valid_o), 64'(vecs[i].e_rv));
      check($sformatf("vec%0d_rd_pc", i), 64'(rd_pc_o), 64'(vecs[i].e_pc));
      check($sformatf("vec%0d_dropped", i), 64'(dropped_o), 64'(vecs[i].e_drop));
    end
    idle_inputs();

    // Asynchronous reset in the middle of a POST phase.
    do_arm(1'b1, 2'b00, 32'h0, 4'd9);
    for (int i = 0; i < 5; i++) retire(32'h40 + 32'(i * 4), 1'b0);
    check("post_state_before_rst", 64'(state_o), 64'd2);
    check("post_count_before_rst", 64'(count_o), 64'd5);
    rst_i = 1'b1;
    #2;
    check("async_rst_state", 64'(state_o), 64'd0);
    check("async_rst_count", 64'(count_o), 64'd0);
    check("async_rst_rd_valid", 64'(rd_valid_o), 64'd0);
    check("async_rst_dropped", 64'(dropped_o), 64'd0);
    step();
    rst_i = 1'b0;
    step();

    // STREAM overflow: 20 retirements into 16 entries with no consumer.
    do_arm(1'b0, 2'b00, 32'h0, 4'd0);
    for (int i = 0; i < 20; i++) retire(32'h1000 + 32'(i * 4), 1'b0);
    check("stream_full_count", 64'(count_o), 64'd16);
    check("stream_dropped", 64'(dropped_o), 64'd4);
    check("stream_head_mask", 64'(rd_mem_mask_o), 64'hC3);
    rd_ready_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("stream_pop%0d_pc", i), 64'(rd_pc_o), 64'(32'h1000 + 32'(i * 4)));
      step();
    end
    rd_ready_i = 1'b0;
    check("stream_drained", 64'(count_o), 64'd0);
    check("stream_drained_valid", 64'(rd_valid_o), 64'd0);

    // Full buffer: simultaneous pop and retirement keeps count and drop count.
    for (int i = 0; i < 16; i++) retire(32'h2000 + 32'(i * 4), 1'b0);
    check("refill_count", 64'(count_o), 64'd16);
    rd_ready_i = 1'b1;
    retire(32'h3000, 1'b0);
    rd_ready_i = 1'b0;
    check("push_pop_full_count", 64'(count_o), 64'd16);
    check("push_pop_full_dropped", 64'(dropped_o), 64'd4);
    check("push_pop_full_head", 64'(rd_pc_o), 64'h2004);

    // FLIGHT, PC trigger at 0x80 with three post-trigger records.
    do_arm(1'b1, 2'b01, 32'h80, 4'd3);
    for (int i = 0; i <= 34; i++) retire(32'(i * 4), 1'b0);
    check("flight_pc_post_state", 64'(state_o), 64'd2);
    check("flight_pc_post_valid", 64'(rd_valid_o), 64'd0);
    retire(32'h8C, 1'b0);
    check("flight_pc_done_state", 64'(state_o), 64'd3);
    retire(32'h90, 1'b0);
    check("flight_pc_count", 64'(count_o), 64'd16);
    rd_ready_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("flight_pc_pop%0d", i), 64'(rd_pc_o), 64'(32'h50 + 32'(i * 4)));
      step();
    end
    rd_ready_i = 1'b0;
    check("flight_pc_empty_state", 64'(state_o), 64'd3);
    check("flight_pc_empty_valid", 64'(rd_valid_o), 64'd0);

    // FLIGHT, trap trigger on the third retirement, no post records.
    do_arm(1'b1, 2'b10, 32'h0, 4'd0);
    retire(32'h500, 1'b0);
    retire(32'h504, 1'b0);
    check("flight_trap_armed", 64'(state_o), 64'd1);
    retire(32'h508, 1'b1);
    retire(32'h50C, 1'b1);
    check("flight_trap_state", 64'(state_o), 64'd3);
    check("flight_trap_count", 64'(count_o), 64'd3);
    rd_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("flight_trap_pc%0d", i), 64'(rd_pc_o), 64'(32'h500 + 32'(i * 4)));
      check($sformatf("flight_trap_flag%0d", i), 64'(rd_trap_o), 64'(i == 2));
      step();
    end
    rd_ready_i = 1'b0;

    // arm_i beats a same-cycle STREAM pop and capture; ts restarts from 0.
    do_arm(1'b0, 2'b00, 32'h0, 4'd0);
    retire(32'h600, 1'b0);
    retire(32'h604, 1'b0);
    arm_i = 1'b1; mode_i = 1'b0; rd_ready_i = 1'b1;
    retire(32'h608, 1'b0);
    arm_i = 1'b0; rd_ready_i = 1'b0;
    check("arm_clears_count", 64'(count_o), 64'd0);
    check("arm_state", 64'(state_o), 64'd1);
    step();
    step();
    retire(32'h700, 1'b0);
    check("after_arm_count", 64'(count_o), 64'd1);
    check("after_arm_pc", 64'(rd_pc_o), 64'h700);
    check("after_arm_ts", 64'(rd_ts_o), 64'd2);
    check("after_arm_insn", 64'(rd_insn_o), 64'(32'h700 ^ 32'h13));
    check("after_arm_mem_addr", 64'(rd_mem_addr_o), 64'h1700);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
